// File: rtl/spi_cpu_pkg.sv
// Shared constants for the 23LC-style SPI SRAM master: opcodes, frame length,
// FSM encoding and the command frame builder.
package spi_cpu_pkg;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_WRITE = 8'h02;
    localparam int         FRAME_LEN = 32;
    localparam int         BIT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Reads clock out a dummy 0x00 byte while the SRAM returns data.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic        we,
        input logic [15:0] addr,
        input logic [7:0]  wdata
    );
        return {(we ? OPC_WRITE : OPC_READ), addr, (we ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock phase generator: CLK_DIV clk cycles low, then CLK_DIV high,
// with single-cycle strobes on the edges that move SCK up and down.
module spi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_MAX = 4'(CLK_DIV - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       wrap;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck  = sck_q;
    assign rise = en && wrap && !sck_q;
    assign fall = en && wrap && sck_q;

endmodule

// File: rtl/spi_mem_master.sv
// Single-byte read/write master for a 23LC-style SPI SRAM: 32-bit frame
// {opcode, addr, data}, MSB first, SPI mode 0.
module spi_mem_master
    import spi_cpu_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   we_q, we_d;
    logic                   cs_n_q, cs_n_d;
    logic                   mosi_q, mosi_d;
    logic                   sck_rise, sck_fall;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_SHIFT),
        .sck  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d   = ST_SHIFT;
                    shift_d   = build_frame(we, addr, wdata);
                    bit_cnt_d = '0;
                    we_d      = we;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_d = {rx_q[6:0], spi_miso};
                end
                // MOSI only advances on the SCK fall so the SRAM sees it stable at the rise.
                if (sck_fall) begin
                    shift_d   = {shift_q[FRAME_LEN-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(FRAME_LEN - 1)) begin
                        state_d = ST_DONE;
                        if (!we_q) rdata_d = rx_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cs_n_d = (state_d != ST_SHIFT);
        mosi_d = (state_d == ST_SHIFT) ? shift_d[FRAME_LEN-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Scoreboard bench for spi_mem_master: instance 0 runs CLK_DIV=1, instance 1
// CLK_DIV=3, each against a behavioural SPI SRAM model.
module tb_spi_mem_master;

    typedef struct {
        int          id;
        logic [31:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, we, busy, done, cs_n, sck, mosi, miso;
    logic [1:0][15:0] addr;
    logic [1:0][7:0]  wdata, rdata;
    logic [1:0][31:0] cap_frame, cap_rises, cap_frames;
    logic [1:0]       gap_exact;

    int   div_of [2] = '{1, 3};
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_mem_master #(.CLK_DIV(1), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .spi_cs_n(cs_n[0]),
        .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_mem_master #(.CLK_DIV(3), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .spi_cs_n(cs_n[1]),
        .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h00FF: return 8'h3C;
            16'h0001: return 8'hC3;
            default:  return a[15:8] ^ a[7:0];
        endcase
    endfunction

    // SRAM model: samples MOSI on SCK rise, drives read data after the SCK fall
    // that ends the 24th bit; MISO is random noise during command and address.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        logic [31:0] frame_r = '0;
        logic [23:0] hdr     = '0;
        logic [7:0]  byte_r  = '0;
        logic        miso_r  = 1'b0;
        int          rises   = 0;
        int          frames  = 0;

        always @(posedge sck[g] or negedge cs_n[g]) begin
            if (!sck[g]) begin
                frame_r = '0;
                rises   = 0;
                frames++;
            end else if (!cs_n[g]) begin
                frame_r = {frame_r[30:0], mosi[g]};
                rises++;
                if (rises == 24) hdr = frame_r[23:0];
            end
        end

        always @(negedge sck[g]) begin
            if (!cs_n[g] && rises >= 24 && rises < 32 && hdr[23:16] == 8'h03) begin
                byte_r = mem_byte(hdr[15:0]);
                miso_r = byte_r[7 - (rises - 24)];
            end else begin
                miso_r = 1'($urandom_range(1, 0));
            end
        end

        assign miso[g]       = miso_r;
        assign cap_frame[g]  = frame_r;
        assign cap_rises[g]  = rises;
        assign cap_frames[g] = frames;
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Monitor: pin rules every cycle, scoreboard pop on every done pulse.
    initial begin : monitor
        int   cyc = 0;
        int   acc_cyc  [2] = '{0, 0};
        int   done_cyc [2] = '{0, 0};
        int   run      [2] = '{0, 0};
        logic cs_n_prev[2] = '{1'b1, 1'b1};
        logic sck_prev [2] = '{1'b0, 1'b0};
        logic mosi_prev[2] = '{1'b0, 1'b0};
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    check("rst_cs_n",  g, 32'(cs_n[g]),  32'd1);
                    check("rst_sck",   g, 32'(sck[g]),   32'd0);
                    check("rst_mosi",  g, 32'(mosi[g]),  32'd0);
                    check("rst_busy",  g, 32'(busy[g]),  32'd0);
                    check("rst_done",  g, 32'(done[g]),  32'd0);
                    check("rst_rdata", g, 32'(rdata[g]), 32'h00);
                end else begin
                    if (cs_n[g]) check("mosi_idle_low", g, 32'(mosi[g]), 32'd0);
                    if (req[g] && !busy[g]) acc_cyc[g] = cyc;
                    if (!cs_n[g]) begin
                        if (cs_n_prev[g]) begin
                            run[g] = 1;
                            // Next frame starts after one idle cycle following done.
                            if (gap_exact[g]) check("b2b_gap", g, 32'(cyc - done_cyc[g]), 32'd2);
                        end else if (sck[g] == sck_prev[g]) begin
                            run[g]++;
                        end else begin
                            check("sck_phase_len", g, 32'(run[g]), 32'(div_of[g]));
                            run[g] = 1;
                        end
                        if (!cs_n_prev[g] && mosi[g] != mosi_prev[g])
                            check("mosi_on_sck_fall", g, {30'd0, sck_prev[g], sck[g]}, 32'b10);
                    end else if (!cs_n_prev[g] && sck_prev[g]) begin
                        check("sck_phase_len", g, 32'(run[g]), 32'(div_of[g]));
                    end
                    if (done[g]) begin
                        done_cyc[g] = cyc;
                        check("done_cs_n", g, 32'(cs_n[g]), 32'd1);
                        check("done_sck",  g, 32'(sck[g]),  32'd0);
                        check("done_busy", g, 32'(busy[g]), 32'd1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_done[%0d]: got done pulse, expected none at %0t", g, $time);
                        end else begin
                            e = exp_q.pop_front();
                            check("sb_instance", g, 32'(g), 32'(e.id));
                            check("mosi_frame",  g, cap_frame[g], e.frame);
                            check("sck_rises",   g, cap_rises[g], 32'd32);
                            check("rdata",       g, 32'(rdata[g]), 32'(e.rdata));
                            check("latency",     g, 32'(cyc - acc_cyc[g]), 32'(1 + 64 * div_of[g]));
                        end
                    end
                end
                cs_n_prev[g] = cs_n[g];
                sck_prev[g]  = sck[g];
                mosi_prev[g] = mosi[g];
            end
        end
    end

    task automatic issue(input int g, input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic [31:0] frame_exp, input logic [7:0] rdata_exp);
        @(posedge clk);
        #1;
        we[g]    = w;
        addr[g]  = a;
        wdata[g] = d;
        req[g]   = 1'b1;
        exp_q.push_back('{g, frame_exp, rdata_exp});
        @(posedge clk);
        #1;
        req[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int limit);
        logic seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = done[g];
        end
        check("done_seen", g, 32'(seen), 32'd1);
    endtask

    initial begin : stimulus
        rst       = 1'b1;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        gap_exact = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 1'b1, 16'h1234, 8'hA5, 32'h021234A5, 8'h00);
        wait_done(0, 200);
        issue(0, 1'b0, 16'h00FF, 8'h77, 32'h0300FF00, 8'h3C);
        wait_done(0, 200);
        issue(0, 1'b1, 16'h4321, 8'h5A, 32'h0243215A, 8'h3C);
        wait_done(0, 200);
        issue(1, 1'b0, 16'h00FF, 8'h00, 32'h0300FF00, 8'h3C);
        wait_done(1, 400);

        // A request mid-transfer must be dropped, not queued.
        issue(0, 1'b0, 16'hBEEF, 8'h00, 32'h03BEEF00, 8'h51);
        repeat (9) @(posedge clk);
        #1;
        we[0] = 1'b1; addr[0] = 16'hDEAD; req[0] = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0; we[0] = 1'b0;
        wait_done(0, 200);
        repeat (100) @(negedge clk);
        check("frames_after_ignored_req", 0, cap_frames[0], 32'd4);

        issue(0, 1'b0, 16'h1111, 8'h00, 32'h03111100, 8'h00);
        for (int i = 0; i < 400 && cap_rises[0] < 20; i++) @(negedge clk);
        check("abort_point_reached", 0, 32'(cap_rises[0] >= 20), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(0, 1'b0, 16'h0001, 8'h00, 32'h03000100, 8'hC3);
        wait_done(0, 200);

        @(posedge clk);
        #1;
        we[0] = 1'b0; addr[0] = 16'h0A0B; req[0] = 1'b1;
        repeat (3) exp_q.push_back('{0, 32'h030A0B00, 8'h01});
        wait_done(0, 200);
        gap_exact[0] = 1'b1;
        wait_done(0, 200);
        wait_done(0, 200);
        #1 req[0] = 1'b0;
        repeat (20) @(negedge clk);
        gap_exact[0] = 1'b0;

        check("frames_total", 0, cap_frames[0], 32'd9);
        check("frames_total", 1, cap_frames[1], 32'd1);
        check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
